// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel complementary PWM core
// and the AXI4-Lite wrapper that programs it.
package pwm_pkg;

  localparam int MAX_CH    = 8;
  localparam int PWM_CNT_W = 16;
  localparam int PWM_DT_W  = 8;

  // Register map seen by the AXI4-Lite slave
  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_PERIOD   = 8'h04;
  localparam logic [7:0] REG_DEADTIME = 8'h08;
  localparam logic [7:0] REG_STATUS   = 8'h0C;
  localparam logic [7:0] REG_DUTY0    = 8'h10;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Carrier-wide configuration; per-channel duties are held beside it
  typedef struct packed {
    pwm_mode_e              mode;
    logic [PWM_CNT_W-1:0]   period;
    logic [PWM_DT_W-1:0]    deadtime;
  } pwm_cfg_t;

  function automatic logic [7:0] reg_duty_off(input int unsigned k);
    return 8'(int'(REG_DUTY0) + 4 * int'(k));
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// One complementary output pair: inserts a programmable gap on every edge
// of the reference so the high and low side are never on together.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = PWM_DT_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            ref_i,
  input  logic            ref_vld_i,
  input  logic [DT_W-1:0] dt_i,
  output logic            pwm_h_o,
  output logic            pwm_l_o
);

  logic [DT_W-1:0] timer_q, timer_d;
  logic            armed_q, armed_d;
  logic            ref_prev_q, ref_prev_d;
  logic            h_q, h_d;
  logic            l_q, l_d;

  always_comb begin
    timer_d    = timer_q;
    armed_d    = armed_q;
    ref_prev_d = ref_prev_q;
    h_d        = h_q;
    l_d        = l_q;
    if (!(en_i && ref_vld_i)) begin
      timer_d    = '0;
      armed_d    = 1'b0;
      ref_prev_d = 1'b0;
      h_d        = 1'b0;
      l_d        = 1'b0;
    end else begin
      armed_d    = 1'b1;
      ref_prev_d = ref_i;
      // The first valid reference after (re)start is treated as an edge so
      // neither side turns on before the gap has elapsed.
      if (!armed_q || (ref_i != ref_prev_q)) begin
        if (dt_i == '0) begin
          timer_d = '0;
          h_d     = ref_i;
          l_d     = !ref_i;
        end else begin
          timer_d = dt_i;
          h_d     = 1'b0;
          l_d     = 1'b0;
        end
      end else if (timer_q > DT_W'(1)) begin
        timer_d = timer_q - DT_W'(1);
        h_d     = 1'b0;
        l_d     = 1'b0;
      end else begin
        timer_d = '0;
        h_d     = ref_i;
        l_d     = !ref_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q    <= '0;
      armed_q    <= 1'b0;
      ref_prev_q <= 1'b0;
      h_q        <= 1'b0;
      l_q        <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      armed_q    <= armed_d;
      ref_prev_q <= ref_prev_d;
      h_q        <= h_d;
      l_q        <= l_d;
    end
  end

  assign pwm_h_o = h_q;
  assign pwm_l_o = l_q;

endmodule

// File: rtl/pwm_multichannel_core.sv
// Shared-carrier PWM core: double-buffered configuration, edge/center carrier,
// per-channel comparators feeding dead-time pairs.
module pwm_multichannel_core
  import pwm_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int CNT_W = PWM_CNT_W,
  parameter int DT_W  = PWM_DT_W
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic                  cfg_enable,
  input  logic                  cfg_center,
  input  logic [CNT_W-1:0]      cfg_period,
  input  logic [DT_W-1:0]       cfg_deadtime,
  input  logic [N_CH*CNT_W-1:0] cfg_duty,
  input  logic                  cfg_load,
  output logic [N_CH-1:0]       pwm_h,
  output logic [N_CH-1:0]       pwm_l,
  output logic                  period_start,
  output logic                  load_ack
);

  pwm_cfg_t         act_q, act_d;
  pwm_cfg_t         pend_q, pend_d;
  logic [CNT_W-1:0] duty_act_q  [N_CH];
  logic [CNT_W-1:0] duty_act_d  [N_CH];
  logic [CNT_W-1:0] duty_pend_q [N_CH];
  logic [CNT_W-1:0] duty_pend_d [N_CH];
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             run_q, run_d;
  logic [N_CH-1:0]  ref_q, ref_d;
  logic             ref_vld_q, ref_vld_d;
  logic             period_start_q, period_start_d;
  logic             load_ack_q, load_ack_d;

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt_nx;
  logic             dir_nx;
  logic             bnd_nx;
  logic             commit;
  logic [DT_W-1:0]  dt_act;

  assign period = CNT_W'(act_q.period);
  assign dt_act = DT_W'(act_q.deadtime);

  // Carrier advance; dir_nx=1 means the center-aligned down phase
  always_comb begin
    cnt_nx = '0;
    dir_nx = 1'b0;
    if (run_q) begin
      if (act_q.mode == PWM_EDGE) begin
        cnt_nx = (cnt_q >= period - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
      end else if (!dir_q) begin
        if (cnt_q >= period - CNT_W'(1)) begin
          cnt_nx = cnt_q;
          dir_nx = 1'b1;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
      end else if (cnt_q == '0) begin
        cnt_nx = '0;
        dir_nx = 1'b0;
      end else begin
        cnt_nx = cnt_q - CNT_W'(1);
        dir_nx = 1'b1;
      end
    end
  end

  // The commit is decided one cycle ahead so the new set is already active
  // in the cnt==0 cycle that starts the next carrier period.
  always_comb begin
    bnd_nx      = !cfg_enable || ((cnt_nx == '0) && !dir_nx);
    commit      = pend_vld_q && bnd_nx;
    act_d       = act_q;
    duty_act_d  = duty_act_q;
    pend_d      = pend_q;
    duty_pend_d = duty_pend_q;
    pend_vld_d  = pend_vld_q;
    if (commit) begin
      act_d      = pend_q;
      duty_act_d = duty_pend_q;
      pend_vld_d = 1'b0;
    end
    if (cfg_load) begin
      pend_d.mode     = cfg_center ? PWM_CENTER : PWM_EDGE;
      pend_d.period   = PWM_CNT_W'(cfg_period);
      pend_d.deadtime = PWM_DT_W'(cfg_deadtime);
      for (int k = 0; k < N_CH; k++) begin
        duty_pend_d[k] = cfg_duty[k*CNT_W +: CNT_W];
      end
      pend_vld_d = 1'b1;
    end
    run_d          = cfg_enable && (CNT_W'(act_d.period) >= CNT_W'(2));
    cnt_d          = run_d ? cnt_nx : '0;
    dir_d          = run_d ? dir_nx : 1'b0;
    period_start_d = run_d && bnd_nx;
    load_ack_d     = commit;
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ref_d[k] = run_q && (cnt_q < duty_act_q[k]);
    end
    ref_vld_d = run_q;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      act_q          <= '0;
      pend_q         <= '0;
      pend_vld_q     <= 1'b0;
      cnt_q          <= '0;
      dir_q          <= 1'b0;
      run_q          <= 1'b0;
      ref_q          <= '0;
      ref_vld_q      <= 1'b0;
      period_start_q <= 1'b0;
      load_ack_q     <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        duty_act_q[k]  <= '0;
        duty_pend_q[k] <= '0;
      end
    end else begin
      act_q          <= act_d;
      pend_q         <= pend_d;
      pend_vld_q     <= pend_vld_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      run_q          <= run_d;
      ref_q          <= ref_d;
      ref_vld_q      <= ref_vld_d;
      period_start_q <= period_start_d;
      load_ack_q     <= load_ack_d;
      for (int k = 0; k < N_CH; k++) begin
        duty_act_q[k]  <= duty_act_d[k];
        duty_pend_q[k] <= duty_pend_d[k];
      end
    end
  end

  // Output stage: dead-time pair per channel, one clock after the reference
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pwm_deadtime #(
      .DT_W(DT_W)
    ) u_dt (
      .clk_i    (s00_axi_aclk),
      .rst_ni   (s00_axi_aresetn),
      .en_i     (cfg_enable),
      .ref_i    (ref_q[k]),
      .ref_vld_i(ref_vld_q),
      .dt_i     (dt_act),
      .pwm_h_o  (pwm_h[k]),
      .pwm_l_o  (pwm_l[k])
    );
  end

  assign period_start = period_start_q;
  assign load_ack     = load_ack_q;

endmodule

// File: tb/tb_pwm_multichannel_core.sv
// Directed bench for pwm_multichannel_core: duty/dead-time/center-mode
// patterns, shadow update, boundary duties, reset and enable behaviour.
module tb_pwm_multichannel_core;

  logic        clk;
  logic        rst_n;
  logic        cfg_enable;
  logic        cfg_center;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_deadtime;
  logic [47:0] cfg_duty;
  logic        cfg_load;
  logic [2:0]  pwm_h;
  logic [2:0]  pwm_l;
  logic        period_start;
  logic        load_ack;

  int checks = 0;
  int errors = 0;
  int ov_any = 0;
  int mh[3], ml[3], mt[3], mcmp[3];
  int mps, mov;

  pwm_multichannel_core #(
    .N_CH(3),
    .CNT_W(16),
    .DT_W(8)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .cfg_enable     (cfg_enable),
    .cfg_center     (cfg_center),
    .cfg_period     (cfg_period),
    .cfg_deadtime   (cfg_deadtime),
    .cfg_duty       (cfg_duty),
    .cfg_load       (cfg_load),
    .pwm_h          (pwm_h),
    .pwm_l          (pwm_l),
    .period_start   (period_start),
    .load_ack       (load_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && |(pwm_h & pwm_l)) ov_any++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_cfg(input logic c, input int p, input int d,
                          input int d0, input int d1, input int d2);
    cfg_center   = c;
    cfg_period   = 16'(p);
    cfg_deadtime = 8'(d);
    cfg_duty     = {16'(d2), 16'(d1), 16'(d0)};
    cfg_load     = 1'b1;
    @(negedge clk);
    cfg_load     = 1'b0;
  endtask

  task automatic measure(input int n);
    logic [2:0] ph;
    ph  = '0;
    mps = 0;
    mov = 0;
    for (int k = 0; k < 3; k++) begin
      mh[k] = 0; ml[k] = 0; mt[k] = 0; mcmp[k] = 0;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        mh[k] += int'(pwm_h[k]);
        ml[k] += int'(pwm_l[k]);
        if (pwm_h[k] == pwm_l[k]) mcmp[k]++;
        if (i > 0 && pwm_h[k] != ph[k]) mt[k]++;
      end
      mps += int'(period_start);
      if (|(pwm_h & pwm_l)) mov++;
      ph = pwm_h;
    end
  endtask

  task automatic wait_ps(input int maxc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic        ok;
    logic [9:0]  v10;
    logic [15:0] v16;
    logic [7:0]  v8;
    logic [10:0] v11;
    logic        hv[30];
    logic        av[30];
    int          s_a, s_b, s_ack;

    rst_n = 1'b0; cfg_enable = 1'b0; cfg_center = 1'b0; cfg_period = '0;
    cfg_deadtime = '0; cfg_duty = '0; cfg_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_h", 32'(pwm_h), 0);
    chk("rst_l", 32'(pwm_l), 0);
    chk("rst_ps", 32'(period_start), 0);
    chk("rst_ack", 32'(load_ack), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Edge mode, P=10, D=0
    load_cfg(1'b0, 10, 0, 3, 5, 0);
    repeat (3) @(negedge clk);
    cfg_enable = 1'b1;
    repeat (20) @(negedge clk);
    measure(100);
    chk("A_h0", mh[0], 30);
    chk("A_l0", ml[0], 70);
    chk("A_cmp0", mcmp[0], 0);
    chk("A_h1", mh[1], 50);
    chk("A_l2_duty0", ml[2], 100);
    chk("A_ps", mps, 10);
    wait_ps(30, ok);
    chk("A_ps_seen", 32'(ok), 1);
    v10[0] = pwm_h[0];
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      v10[i] = pwm_h[0];
    end
    chk("A_phase", 32'(v10), 32'h01C);

    // Edge mode, P=10, D=2
    load_cfg(1'b0, 10, 2, 3, 5, 0);
    repeat (30) @(negedge clk);
    measure(1000);
    chk("B_h1", mh[1], 300);
    chk("B_l1", ml[1], 300);
    chk("B_h0", mh[0], 100);
    chk("B_l0", ml[0], 500);
    chk("B_overlap", mov, 0);
    chk("B_ps", mps, 100);

    // Center mode, P=8, D=0, duty 4
    load_cfg(1'b1, 8, 0, 4, 4, 4);
    repeat (40) @(negedge clk);
    measure(160);
    chk("C_h0", mh[0], 80);
    chk("C_ps", mps, 10);
    wait_ps(40, ok);
    chk("C_ps_seen", 32'(ok), 1);
    v16[0] = pwm_h[0];
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      v16[i] = pwm_h[0];
    end
    chk("C_phase", 32'(v16), 32'hC03F);

    // Shadow update of duty0 3->7 requested at cnt=4
    load_cfg(1'b0, 10, 0, 3, 5, 0);
    repeat (40) @(negedge clk);
    wait_ps(30, ok);
    chk("D_ps_seen", 32'(ok), 1);
    hv[0] = pwm_h[0];
    av[0] = load_ack;
    for (int i = 1; i < 30; i++) begin
      @(negedge clk);
      if (i == 5) cfg_load = 1'b0;
      hv[i] = pwm_h[0];
      av[i] = load_ack;
      if (i == 4) begin
        cfg_duty[15:0] = 16'd7;
        cfg_load       = 1'b1;
      end
    end
    s_a = 0; s_b = 0; s_ack = 0;
    for (int i = 0; i < 30; i++) begin
      if (i >= 2 && i <= 11) s_a += int'(hv[i]);
      if (i >= 12 && i <= 21) s_b += int'(hv[i]);
      s_ack += int'(av[i]);
    end
    chk("D_old_high", s_a, 3);
    chk("D_new_high", s_b, 7);
    chk("D_ack_count", s_ack, 1);
    chk("D_ack_at_cnt0", 32'(av[10]), 1);

    // duty == P
    load_cfg(1'b0, 10, 0, 10, 5, 0);
    repeat (30) @(negedge clk);
    measure(50);
    chk("E_h0", mh[0], 50);
    chk("E_l0", ml[0], 0);
    chk("E_tog0", mt[0], 0);

    // P=1
    load_cfg(1'b0, 1, 0, 3, 5, 0);
    repeat (20) @(negedge clk);
    measure(30);
    chk("F_h", mh[0] + mh[1] + mh[2], 0);
    chk("F_l", ml[0] + ml[1] + ml[2], 0);
    chk("F_ps", mps, 0);

    // Asynchronous reset at cnt=6
    load_cfg(1'b0, 10, 0, 8, 5, 0);
    repeat (30) @(negedge clk);
    wait_ps(30, ok);
    chk("G_ps_seen", 32'(ok), 1);
    repeat (6) @(negedge clk);
    chk("G_pre_h0", 32'(pwm_h[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("G_async_h", 32'(pwm_h), 0);
    chk("G_async_l", 32'(pwm_l), 0);
    chk("G_async_ps", 32'(period_start), 0);
    cfg_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Enable falls mid-period
    load_cfg(1'b0, 10, 0, 3, 5, 0);
    repeat (3) @(negedge clk);
    cfg_enable = 1'b1;
    repeat (25) @(negedge clk);
    chk("H_running", 32'(pwm_h[1] ^ pwm_l[1]), 1);
    cfg_enable = 1'b0;
    @(negedge clk);
    chk("H_off_h", 32'(pwm_h), 0);
    chk("H_off_l", 32'(pwm_l), 0);
    chk("H_off_ps", 32'(period_start), 0);

    // Re-enable with D=3
    load_cfg(1'b0, 10, 3, 3, 5, 0);
    repeat (3) @(negedge clk);
    cfg_enable = 1'b1;
    v8  = '0;
    v11 = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) chk("I_ps_first", 32'(period_start), 1);
      if (i < 8) v8[i] = pwm_h[1];
      v11[i] = pwm_l[1];
    end
    chk("I_h1_edges", 32'(v8), 32'h60);
    chk("I_l1_edges", 32'(v11), 32'h400);
    chk("overlap_total", ov_any, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
